// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// presents the fetched word until consumed, redirects on taken branches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nx;
  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_nx;
  logic        r_valid;
  logic        w_valid_nx;
  logic [31:0] w_tgt;

  assign w_tgt = {branch_target[31:2], 2'b00};

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_instr_nx  = r_instr;
    w_pc_out_nx = r_pc_out;
    w_valid_nx  = r_valid;
    case (r_state)
      S_FETCH: begin
        // request to the old PC is already out, so a redirect must
        // wait for its orphaned response
        if (branch_taken) begin
          w_pc_nx    = w_tgt;
          w_state_nx = S_DISCARD;
        end else begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          w_pc_nx    = w_tgt;
          w_state_nx = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid) begin
          w_instr_nx  = imem_rdata;
          w_pc_out_nx = r_pc;
          w_valid_nx  = 1'b1;
          w_state_nx  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (branch_taken) begin
          w_valid_nx = 1'b0;
          w_instr_nx = NOP_INSTR;
          w_pc_nx    = w_tgt;
          w_state_nx = S_FETCH;
        end else if (!stall) begin
          w_valid_nx = 1'b0;
          w_instr_nx = NOP_INSTR;
          w_pc_nx    = r_pc + 32'd4;
          w_state_nx = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (branch_taken) begin
          w_pc_nx = w_tgt;
        end
        if (imem_rvalid) begin
          w_state_nx = S_FETCH;
        end
      end
      default: w_state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_pc_out <= 32'h0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_instr  <= w_instr_nx;
      r_pc_out <= w_pc_out_nx;
      r_valid  <= w_valid_nx;
    end
  end

  assign imem_req    = (r_state == S_FETCH) && rst;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc_out;
  assign instruction = r_instr;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// checked against a transaction-level model of PC flow and memory.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        instr_valid;

  fetch_stage #(
    .RESET_PC (RPC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          lat = 1;
  bit          rand_lat = 0;
  bit          busy = 0;
  bit          fresh = 0;
  int          cnt = 0;
  logic [31:0] raddr = '0;
  logic [31:0] m_pc = RPC;
  bit          exp_valid = 0;
  logic [31:0] exp_instr = NOP;
  logic [31:0] exp_pcout = '0;
  logic        last_req = 0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive inputs, play memory, advance the model, check
  task automatic cyc(input logic r, input logic st, input logic br,
                     input logic [31:0] tgt);
    logic        rv;
    logic        er;
    logic [31:0] rd;
    logic [31:0] a0;
    @(negedge clk);
    rst = r;
    stall = st;
    branch_taken = br;
    branch_target = tgt;
    rv = 1'b0;
    rd = $urandom;
    if (r && busy) begin
      cnt--;
      if (cnt == 0) begin
        rv = 1'b1;
        rd = word(raddr);
      end
    end
    imem_rvalid = rv;
    imem_rdata = rd;
    #1;
    er = r && !busy && !exp_valid;
    chk("imem_req", {31'b0, imem_req}, {31'b0, er});
    if (er) chk("imem_addr", imem_addr, m_pc);
    last_req = imem_req;
    last_addr = imem_addr;
    a0 = m_pc;
    @(posedge clk);
    #1;
    if (!r) begin
      m_pc = RPC;
      busy = 0;
      exp_valid = 0;
      exp_instr = NOP;
      exp_pcout = '0;
    end else begin
      if (exp_valid && (br || !st)) begin
        exp_valid = 0;
        exp_instr = NOP;
        if (!br) m_pc = m_pc + 32'd4;
      end
      if (br) m_pc = {tgt[31:2], 2'b00};
      if (er) begin
        busy = 1;
        raddr = a0;
        fresh = !br;
        cnt = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end else if (busy) begin
        if (br) fresh = 0;
        if (rv) begin
          busy = 0;
          if (fresh) begin
            exp_valid = 1;
            exp_instr = rd;
            exp_pcout = raddr;
          end
        end
      end
    end
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    chk("instruction", instruction, exp_instr);
    chk("pc_out", pc_out, exp_pcout);
  endtask

  task automatic wait_valid(input string tag, input int n);
    int k = 0;
    while (instr_valid !== 1'b1 && k < n) begin
      cyc(1, 0, 0, 0);
      k++;
    end
    chk(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input int n);
    int k = 0;
    do begin
      cyc(1, 0, 0, 0);
      k++;
    end while (last_req !== 1'b1 && k < n);
    chk(tag, {31'b0, last_req}, 32'd1);
  endtask

  initial begin
    clk = 0;
    rst = 0;
    stall = 0;
    branch_taken = 0;
    branch_target = '0;
    imem_rvalid = 0;
    imem_rdata = '0;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 0) chk("first_req", last_addr, RPC);
      if (i == 1 || i == 2) chk("gap", {31'b0, last_req}, 32'd0);
      if (i == 3) chk("period3", last_addr, 32'h104);
    end

    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0);
      chk("stall_word", instruction, 32'hDEAD_BEEF);
      chk("stall_req", {31'b0, last_req}, 32'd0);
    end
    lat = 3;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("req_108", last_addr, 32'h108);

    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h2002);
    wait_valid("br_valid", 20);
    chk("br_pcout", pc_out, 32'h2000);
    chk("br_word", instruction, word(32'h2000));

    lat = 2;
    cyc(1, 1, 1, 32'h400);
    chk("bst_valid", {31'b0, instr_valid}, 32'd0);
    chk("bst_nop", instruction, NOP);
    cyc(1, 0, 0, 0);
    chk("bst_req", last_addr, 32'h400);

    cyc(1, 0, 1, 32'hFFFF_FFFC);
    wait_valid("wrap_valid", 20);
    chk("wrap_pcout", pc_out, 32'hFFFF_FFFC);
    lat = 3;
    wait_req("wrap_req", 5);
    chk("wrap_addr", last_addr, 32'h0);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_nop", instruction, NOP);
    cyc(1, 0, 0, 0);
    chk("rst_req", last_addr, RPC);

    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      cyc(logic'($urandom_range(0, 199) != 0),
          logic'($urandom_range(0, 9) < 3),
          logic'($urandom_range(0, 9) == 0),
          $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined core, directly upstream of the IF/ID segment register. It owns the program counter and issues one instruction-memory request at a time, tolerating variable memory latency. It presents each fetched word with its address on `instruction`/`pc_out`, holds it under downstream stall, and redirects on taken branches, discarding any stale in-flight response.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: word driven on `instruction` whenever `instr_valid`=0.
- `clk`  in  1: single clock. All state updates occur on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `stall`  in  1: downstream not accepting. Holds the presented instruction.
- `branch_taken`  in  1: redirect request. Takes priority over `stall`.
- `branch_target`  in  32: redirect address. Bits [1:0] are forced to 0.
- `imem_req`  out  1: request strobe, one cycle per request.
- `imem_addr`  out  32: request address, equal to current PC.
- `imem_rvalid`  in  1: response valid. Arrives at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32: response word, valid with `imem_rvalid`.
- `pc_out`  out  32: address of the presented instruction.
- `instruction`  out  32: presented instruction word.
- `instr_valid`  out  1: `instruction`/`pc_out` hold a real fetched word.

## Operation

- Internal registers: `pc` (32-bit) and `state` ∈ {FETCH, WAIT, PRESENT, DISCARD}.
- `imem_req` = (state==FETCH) and `rst`=1, combinational. `imem_addr` = `pc`, combinational.
- Reset (`rst`=0 at an edge):
  - state ← FETCH, `pc` ← RESET_PC.
  - `instr_valid` ← 0, `instruction` ← NOP_INSTR, `pc_out` ← 0.
  - Instruction memory shares this reset, so no response crosses a reset. Reset mid-operation drops everything.
- FETCH: request issued this cycle.
  - With `branch_taken`: `pc` ← target, go to DISCARD, since the request to the old PC is already out.
  - Otherwise go to WAIT.
- WAIT:
  - `imem_rvalid` and no branch: `instruction` ← `imem_rdata`, `pc_out` ← `pc`, `instr_valid` ← 1, go to PRESENT.
  - `branch_taken` with `imem_rvalid` in the same cycle: data dropped, `pc` ← target, go to FETCH.
  - `branch_taken` without `imem_rvalid`: `pc` ← target, go to DISCARD.
- PRESENT: an instruction is consumed at an edge where `instr_valid`=1 and `stall`=0.
  - `branch_taken`: `instr_valid` ← 0, `instruction` ← NOP_INSTR, `pc` ← target, go to FETCH.
  - `stall`=1: all outputs held unchanged.
  - `stall`=0: `instr_valid` ← 0, `instruction` ← NOP_INSTR, `pc` ← `pc`+4, go to FETCH.
- DISCARD: waits for the orphaned response.
  - `imem_rvalid` drops the data and goes to FETCH.
  - `branch_taken` here updates `pc` ← target. It still exits on `imem_rvalid`, including the same cycle.
- While `instr_valid`=0, `pc_out` retains its last presented value (0 after reset).
- `pc`+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- `imem_rvalid` outside WAIT/DISCARD is a protocol error and is ignored.

## Timing

- Outputs are registered on the rising edge, so they are stable for the IF/ID register's falling-edge sample.
- Memory latency L≥1 cycles, with the request in cycle 0:
  - `imem_rvalid` arrives in cycle L.
  - `instr_valid`=1 in cycle L+1.
  - With no stall, the next request is in cycle L+2.
  - Steady-state period is L+2 cycles per instruction.
- First `imem_req` is in the first cycle with `rst`=1.
- Branch: `branch_taken` sampled at edge N makes the new-target request appear in cycle N+1 (from PRESENT, or WAIT with rvalid). From FETCH/WAIT without rvalid, it appears in the cycle after the orphan response.
- `stall` has no effect outside PRESENT.

## Test plan

- Reset, RESET_PC=0x100, L=1, no stall → requests at 0x100, 0x104, 0x108 every 3 cycles. Each `pc_out`/`instruction` pair matches, `instr_valid` pulses 1 cycle.
- `stall` held 4 cycles during PRESENT with word 0xDEADBEEF at 0x104 → outputs and `instr_valid`=1 constant for 4 cycles. No `imem_req` until release, then a request at 0x108.
- L=3, `branch_taken` to 0x2002 in the second WAIT cycle → orphan response discarded, `instr_valid` stays 0. Next request is at 0x2000, whose word is presented with `pc_out`=0x2000.
- `branch_taken` to 0x400 with `stall`=1 in PRESENT → `instr_valid` 0 next cycle, `instruction`=NOP_INSTR, request at 0x400.
- PC at 0xFFFF_FFFC consumed → next request at 0x0000_0000.
- `rst`=0 asserted during WAIT → next cycle `instr_valid`=0, `pc_out`=0, `instruction`=NOP_INSTR. Fetch restarts at RESET_PC after release.
